pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL provide parameter NOP_INST, default 32'h00000013, the instruction word used for a bubble (addi x0,x0,0).
REQ-002 The block SHALL provide parameter CNT_W, default 16, the width of the bubble counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 inst_data_ID  input  32  instruction word in decode.
REQ-007 valid_ID  input  1  decode holds a real instruction.
REQ-008 regwrite_ID  input  1  decode instruction writes rd.
REQ-009 memread_ID  input  1  decode instruction is a load.
REQ-010 flush_EX  input  1  taken branch or jump resolved in EX; squash the decode instruction.
REQ-011 inst_data_EX, inst_data_MEM, inst_data_WB  output  32 each  registered instruction words per stage, consumed by forwarding.
REQ-012 regwrite_EX, regwrite_MEM, regwrite_WB  output  1 each  registered write-enables per stage.
REQ-013 memread_EX  output  1  registered load flag in EX.
REQ-014 stall  output  1  combinational; holds PC and the IF/ID register this cycle.
REQ-015 bubble_count  output  CNT_W  saturating count of inserted bubbles.

Function
REQ-016 The block SHALL take rd=[11:7], rs1=[19:15] and rs2=[24:20] from each instruction word.
REQ-017 rs1_used SHALL be 1 unless opcode [6:0] is 0110111 (LUI), 0010111 (AUIPC) or 1101111 (JAL).
REQ-018 rs2_used SHALL be 1 only for opcode 0110011 (R), 0100011 (S) or 1100011 (B).
REQ-019 hazard SHALL be: memread_EX && rd_EX!=0 && valid_ID && ((rs1_used && rs1_ID==rd_EX) || (rs2_used && rs2_ID==rd_EX)).
REQ-020 stall SHALL be hazard && !flush_EX && !rst (flush has priority over stall).
REQ-021 Every non-reset cycle the block SHALL shift WB<=MEM and MEM<=EX for the inst_data and regwrite outputs.
REQ-022 EX SHALL load a bubble (inst=NOP_INST, regwrite=0, memread=0) when stall, flush_EX or !valid_ID is high; otherwise it SHALL load inst_data_ID, memread_ID, and regwrite_ID && rd_ID!=0.
REQ-023 regwrite in any stage SHALL never be 1 when that stage's rd is 0.
REQ-024 A single load-use SHALL produce exactly one stall cycle; the next cycle EX holds a bubble, so hazard is 0.
REQ-025 Latency from ID to EX, EX to MEM and MEM to WB SHALL each be one cycle; a stalled ID instruction enters EX one cycle late.
REQ-026 bubble_count SHALL increment by 1 on each clock edge at which EX loads a bubble because of stall or flush_EX, and SHALL saturate at all-ones.
REQ-027 Bubbles caused only by !valid_ID SHALL NOT be counted.
REQ-028 When stall and flush_EX are both high in one cycle, the block SHALL count one bubble only.

Reset
REQ-029 On a clock edge with rst=1, inst_data_EX/MEM/WB SHALL become NOP_INST, all regwrite outputs and memread_EX SHALL become 0, and bubble_count SHALL become 0.
REQ-030 Reset SHALL override every load and shift, including mid-stall and mid-flush; stall SHALL read 0 while rst=1.

Verification
REQ-031 Reset check: drive rst=1 for 2 cycles with any inputs -> all inst outputs read 32'h00000013, all regwrite outputs 0, memread_EX 0, stall 0, bubble_count 0.
REQ-032 Load-use: lw x5,0(x1) followed by add x6,x5,x2 -> stall=1 for one cycle; EX holds NOP for one cycle, then the add; bubble_count=1; the lw reaches WB with regwrite_WB=1.
REQ-033 False-hazard filter: lw x5 followed by lui x5,1, then lw x0 followed by add x6,x0,x0 -> stall stays 0; bubble_count unchanged.
REQ-034 Flush priority: load-use pair with flush_EX=1 in the stall cycle -> stall=0; EX loads NOP; bubble_count increments by exactly 1.
REQ-035 Saturation and rd=0: preload bubble_count to 16'hFFFE and force 3 flushes -> count ends at 16'hFFFF. Issue addi x0,x1,1 with regwrite_ID=1 -> regwrite_EX=0.
REQ-036 Mid-operation reset: assert rst during the stall cycle -> next edge gives the REQ-029 state; the held instruction then enters EX normally after rst drops.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Load-use hazard detection and ID->EX->MEM->WB control pipeline.
// Inserts one-cycle bubbles on load-use stalls or EX flushes and counts them.
module pipe_hazard_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_data_ID,
  input  logic             valid_ID,
  input  logic             regwrite_ID,
  input  logic             memread_ID,
  input  logic             flush_EX,
  output logic [31:0]      inst_data_EX,
  output logic [31:0]      inst_data_MEM,
  output logic [31:0]      inst_data_WB,
  output logic             regwrite_EX,
  output logic             regwrite_MEM,
  output logic             regwrite_WB,
  output logic             memread_EX,
  output logic             stall,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R || opcode == OP_S || opcode == OP_B);
  endfunction

  logic [31:0]      inst_ex_q, inst_ex_d;
  logic [31:0]      inst_mem_q, inst_mem_d;
  logic [31:0]      inst_wb_q, inst_wb_d;
  logic             regwrite_ex_q, regwrite_ex_d;
  logic             regwrite_mem_q, regwrite_mem_d;
  logic             regwrite_wb_q, regwrite_wb_d;
  logic             memread_ex_q, memread_ex_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic [4:0] rd_id, rs1_id, rs2_id, rd_ex;
  logic       rs1_used, rs2_used;
  logic       hazard;
  logic       insert_bubble;
  logic       count_bubble;

  assign rd_id    = inst_data_ID[11:7];
  assign rs1_id   = inst_data_ID[19:15];
  assign rs2_id   = inst_data_ID[24:20];
  assign rd_ex    = inst_ex_q[11:7];
  assign rs1_used = uses_rs1(inst_data_ID[6:0]);
  assign rs2_used = uses_rs2(inst_data_ID[6:0]);

  assign hazard = memread_ex_q && (rd_ex != 5'd0) && valid_ID &&
                  ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));

  // A flush squashes the dependent instruction anyway, so it wins over the stall.
  assign stall         = hazard && !flush_EX && !rst;
  assign insert_bubble = stall || flush_EX || !valid_ID;
  // Stall and flush can coincide only as one bubble; invalid-ID bubbles are not counted.
  assign count_bubble  = stall || flush_EX;

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    inst_wb_d      = inst_mem_q;
    regwrite_wb_d  = regwrite_mem_q;
    inst_mem_d     = inst_ex_q;
    regwrite_mem_d = regwrite_ex_q;
    inst_ex_d      = NOP_INST;
    regwrite_ex_d  = 1'b0;
    memread_ex_d   = 1'b0;
    bubble_cnt_d   = bubble_cnt_q;

    if (!insert_bubble) begin
      inst_ex_d     = inst_data_ID;
      regwrite_ex_d = regwrite_ID && (rd_id != 5'd0);
      memread_ex_d  = memread_ID;
    end

    if (count_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_ex_q      <= NOP_INST;
      inst_mem_q     <= NOP_INST;
      inst_wb_q      <= NOP_INST;
      regwrite_ex_q  <= 1'b0;
      regwrite_mem_q <= 1'b0;
      regwrite_wb_q  <= 1'b0;
      memread_ex_q   <= 1'b0;
      bubble_cnt_q   <= '0;
    end else begin
      inst_ex_q      <= inst_ex_d;
      inst_mem_q     <= inst_mem_d;
      inst_wb_q      <= inst_wb_d;
      regwrite_ex_q  <= regwrite_ex_d;
      regwrite_mem_q <= regwrite_mem_d;
      regwrite_wb_q  <= regwrite_wb_d;
      memread_ex_q   <= memread_ex_d;
      bubble_cnt_q   <= bubble_cnt_d;
    end
  end

  assign inst_data_EX  = inst_ex_q;
  assign inst_data_MEM = inst_mem_q;
  assign inst_data_WB  = inst_wb_q;
  assign regwrite_EX   = regwrite_ex_q;
  assign regwrite_MEM  = regwrite_mem_q;
  assign regwrite_WB   = regwrite_wb_q;
  assign memread_EX    = memread_ex_q;
  assign bubble_count  = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: reset, load-use stall,
// false-hazard filtering, flush priority, rd=0 gating, mid-stall reset, saturation.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] LW_X5   = 32'h0000_A283; // lw   x5,0(x1)
  localparam logic [31:0] ADD_DEP = 32'h0022_8333; // add  x6,x5,x2
  localparam logic [31:0] ADD_RS2 = 32'h0051_0333; // add  x6,x2,x5
  localparam logic [31:0] LUI_1   = 32'h0000_12B7; // lui  x5,1
  localparam logic [31:0] LUI_28  = 32'h0002_82B7; // lui  x5,0x28 (rs1 field = 5)
  localparam logic [31:0] LW_X0   = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] ADD_X0  = 32'h0000_0333; // add  x6,x0,x0
  localparam logic [31:0] ADDI_X0 = 32'h0010_8013; // addi x0,x1,1

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_data_ID;
  logic        valid_ID, regwrite_ID, memread_ID, flush_EX;
  logic [31:0] inst_data_EX, inst_data_MEM, inst_data_WB;
  logic        regwrite_EX, regwrite_MEM, regwrite_WB, memread_EX, stall;
  logic [15:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .inst_data_ID (inst_data_ID),
    .valid_ID     (valid_ID),
    .regwrite_ID  (regwrite_ID),
    .memread_ID   (memread_ID),
    .flush_EX     (flush_EX),
    .inst_data_EX (inst_data_EX),
    .inst_data_MEM(inst_data_MEM),
    .inst_data_WB (inst_data_WB),
    .regwrite_EX  (regwrite_EX),
    .regwrite_MEM (regwrite_MEM),
    .regwrite_WB  (regwrite_WB),
    .memread_EX   (memread_EX),
    .stall        (stall),
    .bubble_count (bubble_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic v, input logic rw,
                       input logic mr, input logic fl);
    inst_data_ID = inst;
    valid_ID     = v;
    regwrite_ID  = rw;
    memread_ID   = mr;
    flush_EX     = fl;
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".inst_ex"},  inst_data_EX,  NOP);
    check({tag, ".inst_mem"}, inst_data_MEM, NOP);
    check({tag, ".inst_wb"},  inst_data_WB,  NOP);
    check({tag, ".rw_all"},   {29'd0, regwrite_EX, regwrite_MEM, regwrite_WB}, 32'd0);
    check({tag, ".memrd_ex"}, {31'd0, memread_EX}, 32'd0);
    check({tag, ".count"},    {16'd0, bubble_count}, 32'd0);
  endtask

  initial begin
    logic [15:0] cnt0;

    // Reset held for two cycles with hazard-shaped inputs and a flush.
    rst = 1'b1;
    drive(ADD_DEP, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    step();
    check("rst.stall", {31'd0, stall}, 32'd0);
    check_reset_state("rst");

    rst = 1'b0;
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Load-use: one stall, a NOP in EX, then the add.
    drive(LW_X5, 1'b1, 1'b1, 1'b1, 1'b0);
    check("lu.lw_nostall", {31'd0, stall}, 32'd0);
    step();
    check("lu.ex_lw", inst_data_EX, LW_X5);
    check("lu.memrd_ex", {31'd0, memread_EX}, 32'd1);
    drive(ADD_DEP, 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu.stall", {31'd0, stall}, 32'd1);
    step();
    check("lu.ex_nop", inst_data_EX, NOP);
    check("lu.rw_ex_nop", {31'd0, regwrite_EX}, 32'd0);
    check("lu.mem_lw", inst_data_MEM, LW_X5);
    check("lu.count", {16'd0, bubble_count}, 32'd1);
    check("lu.stall_clear", {31'd0, stall}, 32'd0);
    step();
    check("lu.ex_add", inst_data_EX, ADD_DEP);
    check("lu.wb_lw", inst_data_WB, LW_X5);
    check("lu.rw_wb", {31'd0, regwrite_WB}, 32'd1);
    check("lu.rw_mem_nop", {31'd0, regwrite_MEM}, 32'd0);

    // Hazard through rs2 of an R-type.
    drive(LW_X5, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(ADD_RS2, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rs2.stall", {31'd0, stall}, 32'd1);
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rs2.invalid_nostall", {31'd0, stall}, 32'd0);
    step();
    check("rs2.count_invalid", {16'd0, bubble_count}, 32'd1);

    // False hazards: LUI does not read rs1, rd_EX = x0 never hazards.
    cnt0 = bubble_count;
    drive(LW_X5, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(LUI_1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ff.lui1", {31'd0, stall}, 32'd0);
    drive(LUI_28, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ff.lui28", {31'd0, stall}, 32'd0);
    step();
    drive(LW_X0, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check("ff.lw_x0_rw", {31'd0, regwrite_EX}, 32'd0);
    drive(ADD_X0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ff.add_x0", {31'd0, stall}, 32'd0);
    step();
    check("ff.ex_add", inst_data_EX, ADD_X0);
    check("ff.count", {16'd0, bubble_count}, {16'd0, cnt0});

    // Flush in the stall cycle: no stall, one bubble counted.
    drive(LW_X5, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(ADD_DEP, 1'b1, 1'b1, 1'b0, 1'b1);
    check("fl.stall", {31'd0, stall}, 32'd0);
    step();
    check("fl.ex_nop", inst_data_EX, NOP);
    check("fl.count", {16'd0, bubble_count}, {16'd0, cnt0 + 16'd1});

    // rd = x0 with regwrite requested.
    drive(ADDI_X0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("rd0.ex", inst_data_EX, ADDI_X0);
    check("rd0.rw_ex", {31'd0, regwrite_EX}, 32'd0);

    // Reset asserted during the stall cycle.
    drive(LW_X5, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(ADD_DEP, 1'b1, 1'b1, 1'b0, 1'b0);
    check("mr.stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr.stall_in_rst", {31'd0, stall}, 32'd0);
    step();
    check_reset_state("mr");
    rst = 1'b0;
    #1;
    check("mr.stall_after", {31'd0, stall}, 32'd0);
    step();
    check("mr.ex_add", inst_data_EX, ADD_DEP);
    check("mr.rw_ex", {31'd0, regwrite_EX}, 32'd1);

    // Saturation: count up to 16'hFFFE with flushes, then three more.
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65534; i++) step();
    check("sat.fffe", {16'd0, bubble_count}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) step();
    check("sat.ffff", {16'd0, bubble_count}, 32'h0000_FFFF);
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("sat.hold", {16'd0, bubble_count}, 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
